// File: rtl/gcd_control_unit.sv
// gcd_control_unit: Moore FSM sequencing the subtractive-Euclid GCD datapath.
// Optional build macro GCD_TIMEOUT_EN adds an ERR state that aborts a run once
// o_iter reaches MAX_ITER without a terminating compare flag.
module gcd_control_unit #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned MAX_ITER = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_a_eq_b,
  input  logic             i_a_gt_b,
  input  logic             i_a_zero,
  input  logic             i_b_zero,
  output logic             o_sel_A,
  output logic             o_sel_B,
  output logic             o_sel_sub,
  output logic             o_sel_R,
  output logic             o_ld_A,
  output logic             o_ld_B,
  output logic             o_ld_R,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic [CNT_W-1:0] o_iter
);

`ifdef GCD_TIMEOUT_EN
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CMP, S_SUB_A, S_SUB_B, S_RESULT, S_DONE, S_ERR
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CMP, S_SUB_A, S_SUB_B, S_RESULT, S_DONE
  } state_t;
`endif

  state_t           state;
  state_t           state_nxt;
  logic             sel_a_nxt;
  logic             sel_b_nxt;
  logic             sel_sub_nxt;
  logic             sel_r_nxt;
  logic             ld_a_nxt;
  logic             ld_b_nxt;
  logic             ld_r_nxt;
  logic             busy_nxt;
  logic             done_nxt;
  logic             err_nxt;
  logic [CNT_W-1:0] iter_nxt;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; outputs are decoded from the next state so the
  // registered outputs always line up with the state they belong to
  always_comb begin
    state_nxt   = state;
    sel_r_nxt   = o_sel_R;
    iter_nxt    = o_iter;
    sel_a_nxt   = 1'b0;
    sel_b_nxt   = 1'b0;
    sel_sub_nxt = 1'b0;
    ld_a_nxt    = 1'b0;
    ld_b_nxt    = 1'b0;
    ld_r_nxt    = 1'b0;
    done_nxt    = 1'b0;
    err_nxt     = 1'b0;

    case (state)
      S_IDLE: begin
        if (i_start) begin
          state_nxt = S_LOAD;
          iter_nxt  = '0;
        end
      end
      S_LOAD:  state_nxt = S_CMP;
      S_CMP: begin
        if (i_a_zero) begin
          state_nxt = S_RESULT;
          sel_r_nxt = 1'b1;
        end else if (i_b_zero || i_a_eq_b) begin
          state_nxt = S_RESULT;
          sel_r_nxt = 1'b0;
`ifdef GCD_TIMEOUT_EN
        end else if (o_iter == CNT_W'(MAX_ITER)) begin
          state_nxt = S_ERR;
`endif
        end else if (i_a_gt_b) begin
          state_nxt = S_SUB_A;
        end else begin
          state_nxt = S_SUB_B;
        end
      end
      S_SUB_A, S_SUB_B: begin
        state_nxt = S_CMP;
        if (o_iter != {CNT_W{1'b1}}) begin
          iter_nxt = o_iter + CNT_W'(1);
        end
      end
      S_RESULT: state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase

    case (state_nxt)
      S_LOAD: begin
        ld_a_nxt = 1'b1;
        ld_b_nxt = 1'b1;
      end
      S_SUB_A: begin
        ld_a_nxt  = 1'b1;
        sel_a_nxt = 1'b1;
      end
      S_SUB_B: begin
        ld_b_nxt    = 1'b1;
        sel_b_nxt   = 1'b1;
        sel_sub_nxt = 1'b1;
      end
      S_RESULT: ld_r_nxt = 1'b1;
      S_DONE:   done_nxt = 1'b1;
`ifdef GCD_TIMEOUT_EN
      S_ERR: begin
        done_nxt = 1'b1;
        err_nxt  = 1'b1;
      end
`endif
      default: ;
    endcase

    busy_nxt = (state_nxt != S_IDLE);
  end

  // Output and iteration-counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_sel_A   <= 1'b0;
      o_sel_B   <= 1'b0;
      o_sel_sub <= 1'b0;
      o_sel_R   <= 1'b0;
      o_ld_A    <= 1'b0;
      o_ld_B    <= 1'b0;
      o_ld_R    <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_iter    <= '0;
    end else begin
      o_sel_A   <= sel_a_nxt;
      o_sel_B   <= sel_b_nxt;
      o_sel_sub <= sel_sub_nxt;
      o_sel_R   <= sel_r_nxt;
      o_ld_A    <= ld_a_nxt;
      o_ld_B    <= ld_b_nxt;
      o_ld_R    <= ld_r_nxt;
      o_busy    <= busy_nxt;
      o_done    <= done_nxt;
      o_iter    <= iter_nxt;
    end
  end

`ifdef GCD_TIMEOUT_EN
  // Timeout pulse register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_err <= 1'b0;
    end else begin
      o_err <= err_nxt;
    end
  end
`else
  // No timeout path: the limit is not consulted and o_err never fires
  logic unused_timeout;
  assign unused_timeout = err_nxt ^ (^CNT_W'(MAX_ITER));
  assign o_err          = 1'b0;
`endif

endmodule

// File: tb/tb_gcd_control_unit.sv
// Directed bench for gcd_control_unit with a behavioural GCD datapath model.
module tb_gcd_control_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_start = 1'b0;
  logic       i_a_eq_b, i_a_gt_b, i_a_zero, i_b_zero;
  logic       o_sel_A, o_sel_B, o_sel_sub, o_sel_R;
  logic       o_ld_A, o_ld_B, o_ld_R, o_busy, o_done, o_err;
  logic [7:0] o_iter;

  logic [15:0] ext_a = '0;
  logic [15:0] ext_b = '0;
  logic [15:0] ra = '0;
  logic [15:0] rb = '0;
  logic [15:0] rr = '0;
  logic [15:0] sub_res;

  int n_cmp = 0;
  int n_bad = 0;
  int n_load = 0, n_suba = 0, n_subb = 0, n_ldr = 0, n_done = 0, n_err = 0, n_sel_bad = 0;

  always #5 clk = ~clk;

  gcd_control_unit #(
    .CNT_W   (8),
`ifdef GCD_TIMEOUT_EN
    .MAX_ITER(3)
`else
    .MAX_ITER(255)
`endif
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_start  (i_start),
    .i_a_eq_b (i_a_eq_b),
    .i_a_gt_b (i_a_gt_b),
    .i_a_zero (i_a_zero),
    .i_b_zero (i_b_zero),
    .o_sel_A  (o_sel_A),
    .o_sel_B  (o_sel_B),
    .o_sel_sub(o_sel_sub),
    .o_sel_R  (o_sel_R),
    .o_ld_A   (o_ld_A),
    .o_ld_B   (o_ld_B),
    .o_ld_R   (o_ld_R),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_err    (o_err),
    .o_iter   (o_iter)
  );

  // Datapath model: operand muxes, subtractor, A/B/R registers and flags
  assign sub_res  = o_sel_sub ? (rb - ra) : (ra - rb);
  assign i_a_eq_b = (ra == rb);
  assign i_a_gt_b = (ra > rb);
  assign i_a_zero = (ra == 16'd0);
  assign i_b_zero = (rb == 16'd0);

  always @(posedge clk) begin
    if (o_ld_A) ra <= o_sel_A ? sub_res : ext_a;
    if (o_ld_B) rb <= o_sel_B ? sub_res : ext_b;
    if (o_ld_R) rr <= o_sel_R ? rb : ra;
  end

  // Event counters over the cycle that just ended
  always @(posedge clk) begin
    if (o_ld_A && o_ld_B) n_load <= n_load + 1;
    if (o_ld_A && o_sel_A) n_suba <= n_suba + 1;
    if (o_ld_B && o_sel_B) n_subb <= n_subb + 1;
    if (o_ld_R) n_ldr <= n_ldr + 1;
    if (o_done) n_done <= n_done + 1;
    if (o_err) n_err <= n_err + 1;
    if ((o_ld_A && o_sel_A && o_sel_sub) || (o_ld_B && o_sel_B && !o_sel_sub))
      n_sel_bad <= n_sel_bad + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Start a run at a negedge and stop at the negedge where o_done is seen
  task automatic do_run(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input bit hold, input int exp_lat, input int exp_iter,
                        input bit exp_selr, input bit exp_err, input logic [15:0] exp_r,
                        input int exp_subs);
    int b_load, b_sub, b_ldr, cyc;
    bit seen;
    ext_a  = a;
    ext_b  = b;
    b_load = n_load;
    b_sub  = n_suba + n_subb;
    b_ldr  = n_ldr;
    i_start = 1'b1;
    @(posedge clk);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1 && !hold) i_start = 1'b0;
      if (o_done) seen = 1'b1;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'(1));
    check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    check({tag, "_iter"}, 32'(o_iter), 32'(exp_iter));
    check({tag, "_sel_R"}, 32'(o_sel_R), 32'(exp_selr));
    check({tag, "_err"}, 32'(o_err), 32'(exp_err));
    check({tag, "_busy"}, 32'(o_busy), 32'(1));
    check({tag, "_result"}, 32'(rr), 32'(exp_r));
    check({tag, "_loads"}, 32'(n_load - b_load), 32'(1));
    check({tag, "_subs"}, 32'(n_suba + n_subb - b_sub), 32'(exp_subs));
    check({tag, "_ld_R"}, 32'(n_ldr - b_ldr), exp_err ? 32'(0) : 32'(1));
  endtask

  // Negedge after a DONE: pulse over, FSM back in IDLE
  task automatic after_done(input string tag);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(o_done), 32'(0));
    check({tag, "_err_pulse"}, 32'(o_err), 32'(0));
    check({tag, "_idle"}, 32'(o_busy), 32'(0));
  endtask

  initial begin
    int base, hits, cyc;
    bit seen;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(o_busy), 32'(0));
    check("rst_iter", 32'(o_iter), 32'(0));
    check("rst_loads", 32'({o_ld_A, o_ld_B, o_ld_R}), 32'(0));
    check("rst_sels", 32'({o_sel_A, o_sel_B, o_sel_sub, o_sel_R}), 32'(0));
    check("rst_done", 32'({o_done, o_err}), 32'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Equal operands: no subtraction
    do_run("eq55", 16'd5, 16'd5, 1'b0, 4, 0, 1'b0, 1'b0, 16'd5, 0);
    after_done("eq55");

    // 12,8: SUB_A then SUB_B, gcd 4
    do_run("g12_8", 16'd12, 16'd8, 1'b0, 8, 2, 1'b0, 1'b0, 16'd4, 2);
    check("g12_8_suba", 32'(n_suba), 32'(1));
    check("g12_8_subb", 32'(n_subb), 32'(1));
    after_done("g12_8");

    // A zero: result taken from B, select held afterwards
    do_run("a0_b9", 16'd0, 16'd9, 1'b0, 4, 0, 1'b1, 1'b0, 16'd9, 0);
    after_done("a0_b9");
    check("a0_b9_sel_R_hold", 32'(o_sel_R), 32'(1));

    // Reset during the second SUB_A of 200,3
    ext_a = 16'd200;
    ext_b = 16'd3;
    i_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_start = 1'b0;
    hits = 0;
    cyc  = 0;
    while (hits < 2 && cyc < 50) begin
      if (o_ld_A && o_sel_A) hits++;
      if (hits < 2) @(negedge clk);
      cyc++;
    end
    check("abort_sub_a_seen", 32'(hits), 32'(2));
    check("abort_iter_before", 32'(o_iter), 32'(1));
    base = n_done + n_ldr;
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(o_busy), 32'(0));
    check("abort_iter", 32'(o_iter), 32'(0));
    check("abort_outs", 32'({o_sel_A, o_sel_B, o_sel_sub, o_sel_R, o_ld_A, o_ld_B, o_ld_R, o_done, o_err}), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_no_done_ldr", 32'(n_done + n_ldr - base), 32'(0));
    check("abort_idle", 32'(o_busy), 32'(0));

    // B zero: result taken from A
    do_run("a7_b0", 16'd7, 16'd0, 1'b0, 4, 0, 1'b0, 1'b0, 16'd7, 0);
    after_done("a7_b0");

    // Start held through a run: restart only after passing through IDLE
    base = n_load;
    do_run("held", 16'd3, 16'd6, 1'b1, 6, 1, 1'b0, 1'b0, 16'd3, 1);
    @(negedge clk);
    check("held_idle_gap", 32'(o_busy), 32'(0));
    @(negedge clk);
    check("held_reload", 32'(o_ld_A && o_ld_B), 32'(1));
    i_start = 1'b0;
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (o_done) seen = 1'b1;
    end
    check("held_second_done", 32'(seen), 32'(1));
    check("held_second_result", 32'(rr), 32'(3));
    check("held_total_loads", 32'(n_load - base), 32'(2));
    after_done("held2");

    // Start pulsed during DONE is ignored
    do_run("pulse", 16'd9, 16'd3, 1'b0, 8, 2, 1'b0, 1'b0, 16'd3, 2);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    base = n_load;
    check("pulse_idle", 32'(o_busy), 32'(0));
    repeat (3) @(negedge clk);
    check("pulse_no_load", 32'(n_load - base), 32'(0));
    check("pulse_still_idle", 32'(o_busy), 32'(0));

`ifdef GCD_TIMEOUT_EN
    // Timeout after three SUB_A: ERR pulse, result register untouched
    do_run("tmo", 16'd200, 16'd1, 1'b0, 9, 3, 1'b0, 1'b1, rr, 3);
    after_done("tmo");
    check("err_total", 32'(n_err), 32'(1));
`else
    // Long run to natural termination
    do_run("g200_1", 16'd200, 16'd1, 1'b0, 402, 199, 1'b0, 1'b0, 16'd1, 199);
    after_done("g200_1");
    // Iteration counter saturates at 255 over 299 subtractions
    do_run("sat", 16'd300, 16'd1, 1'b0, 602, 255, 1'b0, 1'b0, 16'd1, 299);
    after_done("sat");
    check("err_total", 32'(n_err), 32'(0));
`endif
    check("sub_order", 32'(n_sel_bad), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
